// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer in front of a single-port DataMemory; one 3-cycle transaction in flight.
// Define DMEM_ARB_RR_EN for round-robin tie-breaking; otherwise requester 0 has fixed priority.
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Req0,
    input  logic                  Req1,
    input  logic                  Wr0,
    input  logic                  Wr1,
    input  logic [ADDR_WIDTH-1:0] Addr0,
    input  logic [ADDR_WIDTH-1:0] Addr1,
    input  logic [DATA_WIDTH-1:0] WData0,
    input  logic [DATA_WIDTH-1:0] WData1,
    output logic                  Done0,
    output logic                  Done1,
    output logic [DATA_WIDTH-1:0] RData,
    output logic [ADDR_WIDTH-1:0] MemAddress,
    output logic [DATA_WIDTH-1:0] MemWriteData,
    output logic                  MemWrite,
    output logic                  MemRead,
    input  logic [DATA_WIDTH-1:0] MemReadData,
    output logic                  Busy,
    output logic                  GrantId
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t                state;
    logic                  winner;
    logic                  sel_wr;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

`ifdef DMEM_ARB_RR_EN
    logic last_winner;

    always_comb begin
        winner = ~Req0;
        if (Req0 && Req1) begin
            winner = ~last_winner;
        end
    end
`else
    always_comb begin
        winner = ~Req0;
    end
`endif

    always_comb begin
        sel_wr    = winner ? Wr1 : Wr0;
        sel_addr  = winner ? Addr1 : Addr0;
        sel_wdata = winner ? WData1 : WData0;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= IDLE;
            Done0        <= 1'b0;
            Done1        <= 1'b0;
            RData        <= '0;
            MemAddress   <= '0;
            MemWriteData <= '0;
            MemWrite     <= 1'b0;
            MemRead      <= 1'b0;
            Busy         <= 1'b0;
            GrantId      <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            last_winner  <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (Req0 || Req1) begin
                        GrantId      <= winner;
                        MemAddress   <= {sel_addr[ADDR_WIDTH-1:2], 2'b00};
                        MemWriteData <= sel_wdata;
                        MemWrite     <= sel_wr;
                        MemRead      <= ~sel_wr;
                        Busy         <= 1'b1;
                        state        <= ACCESS;
`ifdef DMEM_ARB_RR_EN
                        last_winner  <= winner;
`endif
                    end
                end
                ACCESS: begin
                    // Memory commits the write / presents read data during this cycle.
                    MemWrite <= 1'b0;
                    MemRead  <= 1'b0;
                    if (MemRead) begin
                        RData <= MemReadData;
                    end
                    if (GrantId) begin
                        Done1 <= 1'b1;
                    end else begin
                        Done0 <= 1'b1;
                    end
                    state <= RESP;
                end
                RESP: begin
                    Done0 <= 1'b0;
                    Done1 <= 1'b0;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a transaction-level model predicts grants, memory
// effects and Done timing; a negedge monitor compares every cycle.
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
`ifdef DMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          Req0 = 1'b0, Req1 = 1'b0, Wr0 = 1'b0, Wr1 = 1'b0;
    logic [AW-1:0] Addr0 = '0, Addr1 = '0;
    logic [DW-1:0] WData0 = '0, WData1 = '0;
    logic          Done0, Done1, MemWrite, MemRead, Busy, GrantId;
    logic [DW-1:0] RData, MemWriteData, MemReadData;
    logic [AW-1:0] MemAddress;

    always #5 Clk = ~Clk;

    dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .Clk(Clk), .Reset(Reset),
        .Req0(Req0), .Req1(Req1), .Wr0(Wr0), .Wr1(Wr1),
        .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
        .Done0(Done0), .Done1(Done1), .RData(RData),
        .MemAddress(MemAddress), .MemWriteData(MemWriteData),
        .MemWrite(MemWrite), .MemRead(MemRead), .MemReadData(MemReadData),
        .Busy(Busy), .GrantId(GrantId)
    );

    // DataMemory stand-in: 16 words, combinational read, write at the clock edge.
    logic [DW-1:0] mem [16] = '{default: '0};
    assign MemReadData = mem[MemAddress[5:2]];
    always @(posedge Clk) if (MemWrite) mem[MemAddress[5:2]] <= MemWriteData;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a granted transaction occupies the memory for one cycle and
    // answers one cycle later; writes land in ref_mem only if that cycle completes.
    typedef struct {
        bit            id;
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int            done_cyc;
    } txn_t;

    txn_t          q[$];
    txn_t          pend;
    logic [DW-1:0] ref_mem [16] = '{default: '0};
    int            cyc = 0;
    int            left = 0;
    bit            ptr = 1'b1;
    logic [DW-1:0] m_rdata = '0;

    always @(posedge Clk or posedge Reset) begin : model
        bit w;
        if (Reset) begin
            left    = 0;
            ptr     = 1'b1;
            m_rdata = '0;
            q.delete();
        end else begin
            cyc++;
            if (left == 0) begin
                if (Req0 || Req1) begin
                    if (Req0 && Req1) w = RR ? !ptr : 1'b0;
                    else              w = Req1;
                    pend.id       = w;
                    pend.wr       = w ? Wr1 : Wr0;
                    pend.addr     = (w ? Addr1 : Addr0) & ~32'h3;
                    pend.wdata    = w ? WData1 : WData0;
                    pend.rdata    = ref_mem[pend.addr[5:2]];
                    pend.done_cyc = cyc + 1;
                    q.push_back(pend);
                    ptr  = w;
                    left = 2;
                end
            end else if (left == 2) begin
                if (pend.wr) ref_mem[pend.addr[5:2]] = pend.wdata;
                else         m_rdata = pend.rdata;
                left = 1;
            end else begin
                left = 0;
            end
        end
    end

    always @(negedge Clk) begin : monitor
        txn_t t;
        if (Reset) begin
            chk("reset_ctrl", {Done0, Done1, Busy, GrantId, MemWrite, MemRead}, 6'b0);
            chk("reset_data", {MemAddress, MemWriteData}, 64'h0);
            chk("reset_rdata", RData, 0);
        end else begin
            chk("busy", Busy, left != 0);
            chk("mem_ctrl", {MemWrite, MemRead}, (left == 2) ? {pend.wr, !pend.wr} : 2'b00);
            if (left == 2) begin
                chk("mem_addr", MemAddress, pend.addr);
                chk("mem_wdata", MemWriteData, pend.wdata);
                chk("grant_id", GrantId, pend.id);
            end
            chk("rdata", RData, m_rdata);
            if (q.size() > 0 && q[0].done_cyc == cyc) begin
                t = q.pop_front();
                chk("done_id", {Done1, Done0}, t.id ? 2'b10 : 2'b01);
            end else if (Done0 || Done1) begin
                chk("unexpected_done", {Done1, Done0}, 2'b00);
            end
        end
    end

    task automatic drive(input bit id, input bit req, input bit wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (id) begin Req1 = req; Wr1 = wr; Addr1 = a; WData1 = d; end
        else    begin Req0 = req; Wr0 = wr; Addr0 = a; WData0 = d; end
    endtask

    // Issue one request and wait (bounded) for its Done; Req is left high when keep=1.
    task automatic txn(input bit id, input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input bit keep, output logic [DW-1:0] rd);
        int n = 0;
        drive(id, 1'b1, wr, a, d);
        do begin @(negedge Clk); n++; end while (!(id ? Done1 : Done0) && n < 80);
        if (!(id ? Done1 : Done0)) chk("txn_timeout", id ? Done1 : Done0, 1);
        rd = RData;
        if (!keep) drive(id, 1'b0, wr, a, d);
    endtask

    task automatic wait_done(output bit id);
        int n = 0;
        do begin @(negedge Clk); n++; end while (!(Done0 || Done1) && n < 40);
        if (!(Done0 || Done1)) chk("wait_done_timeout", {Done1, Done0}, 2'b01);
        id = Done1;
    endtask

    task automatic rand_driver(input bit id);
        logic [DW-1:0] rd;
        int gap;
        for (int k = 0; k < 40; k++) begin
            gap = $urandom_range(0, 2);
            txn(id, 1'(($urandom() & 1)), $urandom(), $urandom(), gap == 0, rd);
            if (gap != 0) repeat (gap) @(negedge Clk);
        end
        drive(id, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [DW-1:0] rd;
        bit id;
        int prev;
        int n;

        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        repeat (10) @(negedge Clk);

        txn(0, 1, 32'h0, 32'h12345678, 0, rd);
        @(negedge Clk);
        txn(0, 0, 32'h0, 32'h0, 0, rd);
        chk("t2_rdata", rd, 32'h12345678);

        @(negedge Clk);
        txn(0, 1, 32'h4, 32'hABCDEF98, 0, rd);
        txn(1, 0, 32'h7, 32'h0, 0, rd);
        chk("t3_rdata", rd, 32'hABCDEF98);
        chk("t3_memaddr", MemAddress, 32'h4);

        drive(0, 1, 1, 32'h8, 32'hA0000000);
        drive(1, 1, 1, 32'hC, 32'hC0000000);
        for (int i = 0; i < 8; i++) begin
            wait_done(id);
            chk("t4_grant", id, RR ? (i % 2) : 0);
            if (i == 7) Req0 = 1'b0;
            else if (id) WData1 = WData1 + 1;
            else WData0 = WData0 + 1;
        end
        wait_done(id);
        chk("t4_after_drop", id, 1);
        Req1 = 1'b0;

        repeat (2) @(negedge Clk);
        txn(0, 1, 32'h8, 32'h5A5A5A5A, 0, rd);
        @(negedge Clk);
        drive(0, 1, 1, 32'h8, 32'hFFFFFFFF);
        n = 0;
        do begin @(negedge Clk); n++; end while (!MemWrite && n < 10);
        chk("t5_access_seen", MemWrite, 1);
        #1 Reset = 1'b1;
        drive(0, 0, 0, '0, '0);
        #1 chk("t5_memwrite_async", MemWrite, 0);
        chk("t5_busy_async", Busy, 0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        repeat (4) @(negedge Clk);
        txn(0, 0, 32'h8, 32'h0, 0, rd);
        chk("t5_rdata", rd, 32'h5A5A5A5A);

        @(negedge Clk);
        drive(0, 1, 0, 32'h10, 32'h0);
        wait_done(id);
        prev = cyc;
        for (int i = 0; i < 4; i++) begin
            Addr0 = Addr0 + 4;
            wait_done(id);
            chk("t6_period", cyc - prev, 3);
            chk("t6_id", id, 0);
            prev = cyc;
        end
        Req0 = 1'b0;

        repeat (3) @(negedge Clk);
        fork
            rand_driver(0);
            rand_driver(1);
        join

        repeat (6) @(negedge Clk);
        chk("final_queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
